// File: rtl/nrzi_stuff_encoder.sv
// Serial line encoder: NRZ / NRZI-mark / NRZI-space coding with optional
// zero-insertion after STUFF_RUN consecutive data 1s. One bit per cycle in, one out.
module nrzi_stuff_encoder #(
    parameter int unsigned STUFF_RUN  = 6,
    parameter logic        INIT_LEVEL = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] mode,
    input  logic       stuff_en,
    input  logic       in_valid,
    input  logic       in_bit,
    output logic       in_ready,
    output logic       out_valid,
    output logic       out_bit,
    output logic       stuff_active
);

    typedef enum logic {
        S_RUN   = 1'b0,
        S_STUFF = 1'b1
    } state_t;

    localparam logic [3:0] RUN_LAST = 4'(STUFF_RUN - 1);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [3:0] r_cnt;
    logic [3:0] w_cnt_nxt;
    logic       r_level;
    logic       w_level_nxt;
    logic       r_out_valid;
    logic       r_stuff_active;
    logic       w_take;
    logic       w_encode;
    logic       w_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= S_RUN;
            r_cnt          <= 4'd0;
            r_level        <= INIT_LEVEL;
            r_out_valid    <= 1'b0;
            r_stuff_active <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_cnt          <= w_cnt_nxt;
            r_level        <= w_level_nxt;
            r_out_valid    <= w_encode;
            r_stuff_active <= (r_state == S_STUFF);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_take      = 1'b0;
        w_encode    = 1'b0;
        w_d         = in_bit;
        case (r_state)
            S_RUN: begin
                w_take   = in_valid;
                w_encode = in_valid;
                if (!stuff_en) begin
                    w_cnt_nxt = 4'd0;
                end else if (w_take) begin
                    if (in_bit) begin
                        w_cnt_nxt = r_cnt + 4'd1;
                        if (r_cnt == RUN_LAST)
                            w_state_nxt = S_STUFF;
                    end else begin
                        w_cnt_nxt = 4'd0;
                    end
                end
            end
            S_STUFF: begin
                // The stuffed 0 goes out even if stuff_en dropped meanwhile.
                w_encode    = 1'b1;
                w_d         = 1'b0;
                w_cnt_nxt   = 4'd0;
                w_state_nxt = S_RUN;
            end
            default: w_state_nxt = S_RUN;
        endcase
    end

    always_comb begin
        w_level_nxt = r_level;
        if (w_encode) begin
            case (mode)
                2'b01:   w_level_nxt = r_level ^ w_d;
                2'b10:   w_level_nxt = r_level ^ ~w_d;
                default: w_level_nxt = w_d;
            endcase
        end
    end

    assign in_ready     = (r_state == S_RUN);
    assign out_valid    = r_out_valid;
    assign out_bit      = r_level;
    assign stuff_active = r_stuff_active;

endmodule

// File: tb/tb_nrzi_stuff_encoder.sv
// Bench: two encoder instances (STUFF_RUN=6/INIT=0 and STUFF_RUN=1/INIT=1) on shared
// inputs, compared every cycle against a rule-level model plus directed expectations.
module tb_nrzi_stuff_encoder;

    logic       clk = 1'b0;
    logic       reset, stuff_en, in_valid, in_bit;
    logic [1:0] mode;
    logic [1:0] rdy, ov, ob, sa;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    nrzi_stuff_encoder #(.STUFF_RUN(6), .INIT_LEVEL(1'b0)) u0 (
        .clk(clk), .reset(reset), .mode(mode), .stuff_en(stuff_en),
        .in_valid(in_valid), .in_bit(in_bit), .in_ready(rdy[0]),
        .out_valid(ov[0]), .out_bit(ob[0]), .stuff_active(sa[0]));

    nrzi_stuff_encoder #(.STUFF_RUN(1), .INIT_LEVEL(1'b1)) u1 (
        .clk(clk), .reset(reset), .mode(mode), .stuff_en(stuff_en),
        .in_valid(in_valid), .in_bit(in_bit), .in_ready(rdy[1]),
        .out_valid(ov[1]), .out_bit(ob[1]), .stuff_active(sa[1]));

    // reference model state, one slot per instance
    int m_runlen[2]   = '{6, 1};
    bit m_init[2]     = '{1'b0, 1'b1};
    bit m_lvl[2];
    int m_ones[2];
    bit m_pend[2], m_ov[2], m_sa[2];

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic bit encode(input bit lvl, input bit d, input logic [1:0] m);
        if (m == 2'b01) return lvl ^ d;
        if (m == 2'b10) return lvl ^ !d;
        return d;
    endfunction

    task automatic model_edge();
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                m_lvl[i] = m_init[i]; m_ones[i] = 0; m_pend[i] = 0; m_ov[i] = 0; m_sa[i] = 0;
            end else if (m_pend[i]) begin
                m_lvl[i] = encode(m_lvl[i], 1'b0, mode);
                m_ones[i] = 0; m_pend[i] = 0; m_ov[i] = 1; m_sa[i] = 1;
            end else if (in_valid) begin
                m_lvl[i] = encode(m_lvl[i], in_bit, mode);
                m_ov[i] = 1; m_sa[i] = 0;
                if (!stuff_en) m_ones[i] = 0;
                else if (in_bit) begin
                    m_ones[i]++;
                    if (m_ones[i] == m_runlen[i]) begin
                        m_pend[i] = 1; m_ones[i] = 0;
                    end
                end else m_ones[i] = 0;
            end else begin
                m_ov[i] = 0; m_sa[i] = 0;
                if (!stuff_en) m_ones[i] = 0;
            end
        end
    endtask

    // one clock: model follows the edge, outputs compared on the falling edge
    task automatic cyc();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("u%0d_out_valid", i), 32'(ov[i]), 32'(m_ov[i]));
            chk($sformatf("u%0d_out_bit", i), 32'(ob[i]), 32'(m_lvl[i]));
            chk($sformatf("u%0d_stuff_active", i), 32'(sa[i]), 32'(m_sa[i]));
            chk($sformatf("u%0d_in_ready", i), 32'(rdy[i]), 32'(!m_pend[i]));
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; in_valid = 1'b0;
        cyc();
        reset = 1'b0;
    endtask

    task automatic send(input bit v, input bit b);
        in_valid = v; in_bit = b;
        cyc();
    endtask

    initial begin
        bit exp1[4];
        int nv, ns;
        reset = 1'b1; mode = 2'b00; stuff_en = 1'b0; in_valid = 1'b0; in_bit = 1'b0;
        @(negedge clk);

        // reset state
        do_reset();
        chk("rst_out_bit_u0", 32'(ob[0]), 32'd0);
        chk("rst_out_bit_u1", 32'(ob[1]), 32'd1);
        chk("rst_out_valid", 32'(ov), 32'd0);
        chk("rst_stuff_active", 32'(sa), 32'd0);
        chk("rst_in_ready", 32'(rdy), 32'd3);

        // NRZI-space, INIT=1, no stuffing: 0,1,0,0 -> 0,0,1,0
        mode = 2'b10; stuff_en = 1'b0;
        exp1 = '{1'b0, 1'b0, 1'b1, 1'b0};
        for (int k = 0; k < 4; k++) begin
            send(1'b1, (k == 1));
            chk("t1_out_bit", 32'(ob[1]), 32'(exp1[k]));
            chk("t1_out_valid", 32'(ov[1]), 32'd1);
            chk("t1_in_ready", 32'(rdy[1]), 32'd1);
        end
        in_valid = 1'b0;

        // NRZI-mark, INIT=0: 1,1,idle,0,1 -> 1,0,(hold 0),0,1
        do_reset();
        mode = 2'b01;
        send(1'b1, 1'b1); chk("t2_b0", 32'(ob[0]), 32'd1);
        send(1'b1, 1'b1); chk("t2_b1", 32'(ob[0]), 32'd0);
        send(1'b0, 1'b0); chk("t2_idle_bit", 32'(ob[0]), 32'd0);
        chk("t2_idle_valid", 32'(ov[0]), 32'd0);
        send(1'b1, 1'b0); chk("t2_b2", 32'(ob[0]), 32'd0);
        send(1'b1, 1'b1); chk("t2_b3", 32'(ob[0]), 32'd1);
        in_valid = 1'b0;

        // NRZI-space with stuffing, eight 1s: 6x level 0, stuffed 1, then 1,1
        do_reset();
        mode = 2'b10; stuff_en = 1'b1;
        nv = 0; ns = 0;
        for (int k = 0; k < 9; k++) begin
            send(1'b1, 1'b1);
            nv += int'(ov[0]); ns += int'(sa[0]);
            chk("t3_out_bit", 32'(ob[0]), (k < 6) ? 32'd0 : 32'd1);
            chk("t3_stuff_active", 32'(sa[0]), 32'(k == 6));
            chk("t3_in_ready", 32'(rdy[0]), 32'(k != 5));
        end
        send(1'b0, 1'b0);
        nv += int'(ov[0]);
        chk("t3_valid_cycles", 32'(nv), 32'd9);
        chk("t3_stuff_count", 32'(ns), 32'd1);

        // idle keeps the run count; a data 0 clears it
        do_reset();
        for (int k = 0; k < 5; k++) send(1'b1, 1'b1);
        for (int k = 0; k < 3; k++) send(1'b0, 1'b0);
        send(1'b1, 1'b1);
        chk("t4_ready_after_6th", 32'(rdy[0]), 32'd0);
        send(1'b0, 1'b0);
        chk("t4_stuffed", 32'(sa[0]), 32'd1);
        do_reset();
        for (int k = 0; k < 5; k++) send(1'b1, 1'b1);
        send(1'b1, 1'b0);
        send(1'b1, 1'b1);
        send(1'b1, 1'b1);
        chk("t4b_no_stuff_ready", 32'(rdy[0]), 32'd1);
        send(1'b0, 1'b0);
        chk("t4b_no_stuff", 32'(sa[0]), 32'd0);

        // reset while the stuff is pending drops the stuffed bit
        do_reset();
        for (int k = 0; k < 6; k++) send(1'b1, 1'b1);
        chk("t5_pending", 32'(rdy[0]), 32'd0);
        do_reset();
        chk("t5_out_valid", 32'(ov[0]), 32'd0);
        chk("t5_out_bit", 32'(ob[0]), 32'd0);
        chk("t5_in_ready", 32'(rdy[0]), 32'd1);
        send(1'b0, 1'b0);
        chk("t5_no_stuff", 32'(sa[0]), 32'd0);

        // mode switch mid-stream: mark(1) -> 1, NRZ(0) -> 0, space(1) -> hold 0
        do_reset();
        stuff_en = 1'b0; mode = 2'b01;
        send(1'b1, 1'b1); chk("t6_mark", 32'(ob[0]), 32'd1);
        mode = 2'b00;
        send(1'b1, 1'b0); chk("t6_nrz", 32'(ob[0]), 32'd0);
        mode = 2'b10;
        send(1'b1, 1'b1); chk("t6_space", 32'(ob[0]), 32'd0);

        // randomized traffic against the model
        for (int k = 0; k < 3000; k++) begin
            reset    = ($urandom_range(63) == 0);
            mode     = 2'($urandom_range(3));
            stuff_en = ($urandom_range(7) != 0);
            in_valid = ($urandom_range(3) != 0);
            in_bit   = ($urandom_range(7) != 0);
            cyc();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
